// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter (8N1, LSB first) with byte FIFO
//
// Purpose: queues bytes written by the core and serialises them onto txd.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (8E1).
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   wr_data   byte to queue
//   wrreq     write strobe, one byte per cycle high
//   full      FIFO full; writes while high are dropped
//   count     bytes queued, excluding the byte on the line
//   txd       serial output, idle high, registered
//   busy      frame in flight or FIFO non-empty
//   overflow  sticky, set by any dropped write

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 wr_data,
    input  logic                       wrreq,
    output logic                       full,
    output logic [FIFO_DEPTH_LOG2:0]   count,
    output logic                       txd,
    output logic                       busy,
    output logic                       overflow
);

    localparam int PW    = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]    mem [DEPTH];

    state_t        state_q,    state_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0] baud_q,     baud_d;
    logic [2:0]    bit_idx_q,  bit_idx_d;
    logic [7:0]    shift_q,    shift_d;
    logic          txd_q,      txd_d;
    logic          overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q,   parity_d;
`endif

    logic          empty;
    logic          wr_en;
    logic          pop;
    logic          bit_end;
    logic [7:0]    head;

    // Extra pointer MSB makes the difference range 0..DEPTH, so full and
    // empty are both distinguishable from registered pointers alone.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == PW'(DEPTH));
    assign empty    = (count == '0);
    assign wr_en    = wrreq & ~full;
    assign pop      = (state_q == S_IDLE) & ~empty;
    assign bit_end  = (baud_q == BAUD_LAST);
    assign head     = mem[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];

    assign txd      = txd_q;
    assign busy     = (state_q != S_IDLE) | ~empty;
    assign overflow = overflow_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + PW'(wr_en);
        rd_ptr_d   = rd_ptr_q;
        baud_d     = bit_end ? '0 : baud_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        txd_d      = txd_q;
        overflow_d = overflow_q | (wrreq & full);
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                txd_d  = 1'b1;
                baud_d = '0;
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    shift_d  = head;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                    state_d  = S_START;
                    txd_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                end
            end
            S_DATA: begin
                // txd is registered, so the next bit is loaded one position
                // ahead of the shift (shift_q[1] becomes shift_d[0]).
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Storage array needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int C  = 4;
    localparam int D2 = 2;
`ifdef UART_TX_PARITY_EN
    localparam int F   = 11 * C;
    localparam bit PAR = 1'b1;
`else
    localparam int F   = 10 * C;
    localparam bit PAR = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [7:0]    wr_data;
    logic          wrreq;
    logic          full;
    logic [D2:0]   count;
    logic          txd;
    logic          busy;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH_LOG2(D2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wrreq    (wrreq),
        .full     (full),
        .count    (count),
        .txd      (txd),
        .busy     (busy),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One active edge; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_data = b;
        wrreq   = 1'b1;
        tick();
        wrreq   = 1'b0;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (PAR && slot == 9) return ^b;
        return 1'b1;
    endfunction

    // Called with the sample after the edge that drove the start bit as
    // index 0 (minus 'skip' samples already elapsed); returns in the
    // cycle after the stop bit.
    task automatic expect_frame(input logic [7:0] b, input int skip, input string tag);
        for (int i = skip; i < F; i++) begin
            chk(32'(txd), 32'(exp_bit(b, i / C)), $sformatf("%s_s%0d", tag, i));
            tick();
        end
    endtask

    initial begin
        logic bad;

        rst_n   = 1'b0;
        wrreq   = 1'b0;
        wr_data = 8'h00;
        repeat (3) @(negedge clk);
        chk(32'(txd), 32'd1, "rst_txd");
        chk(32'(full), 32'd0, "rst_full");
        chk(32'(count), 32'd0, "rst_count");
        chk(32'(busy), 32'd0, "rst_busy");
        chk(32'(overflow), 32'd0, "rst_overflow");
        rst_n = 1'b1;
        tick();
        chk(32'(txd), 32'd1, "idle_txd");

        // Single byte 0x55: popped at edge 1, busy falls at edge 1+F.
        write_byte(8'h55);
        chk(32'(count), 32'd1, "t1_count_after_wr");
        chk(32'(txd), 32'd1, "t1_txd_before_pop");
        chk(32'(busy), 32'd1, "t1_busy_queued");
        tick();
        chk(32'(count), 32'd0, "t1_count_after_pop");
        expect_frame(8'h55, 0, "t1");
        chk(32'(busy), 32'd0, "t1_busy_end");
        chk(32'(txd), 32'd1, "t1_txd_end");

        // Back-to-back 0xA3, 0x0F: count 1,1 then 0 on second pop.
        write_byte(8'hA3);
        chk(32'(count), 32'd1, "t2_count_a");
        write_byte(8'h0F);
        chk(32'(count), 32'd1, "t2_count_b");
        expect_frame(8'hA3, 0, "t2a");
        chk(32'(txd), 32'd1, "t2_gap_txd");
        chk(32'(count), 32'd1, "t2_gap_count");
        tick();
        chk(32'(count), 32'd0, "t2_count_c");
        expect_frame(8'h0F, 0, "t2b");
        chk(32'(busy), 32'd0, "t2_busy_end");

        // Depth-4 FIFO: six writes, 0x06 dropped.
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        write_byte(8'h04);
        write_byte(8'h05);
        chk(32'(full), 32'd1, "t3_full");
        chk(32'(overflow), 32'd0, "t3_ovf_pre");
        write_byte(8'h06);
        chk(32'(count), 32'd4, "t3_count");
        chk(32'(full), 32'd1, "t3_full_after_drop");
        chk(32'(overflow), 32'd1, "t3_overflow");
        expect_frame(8'h01, 4, "t3_01");
        for (int k = 2; k <= 5; k++) begin
            chk(32'(txd), 32'd1, $sformatf("t3_gap%0d", k));
            tick();
            expect_frame(8'(k), 0, $sformatf("t3_%0d", k));
        end
        chk(32'(count), 32'd0, "t3_count_end");
        bad = 1'b0;
        for (int k = 0; k < 3 * F; k++) begin
            if (txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
            tick();
        end
        chk(32'(bad), 32'd0, "t3_no_extra_frame");
        chk(32'(overflow), 32'd1, "t3_overflow_sticky");

        // Reset during data bit 3 of 0xFF with 3 bytes queued.
        write_byte(8'hFF);
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        chk(32'(count), 32'd3, "t4_count_queued");
        repeat (15) tick();
        chk(32'(txd), 32'd1, "t4_txd_bit3");
        chk(32'(busy), 32'd1, "t4_busy_pre");
        #1 rst_n = 1'b0;
        #1;
        chk(32'(txd), 32'd1, "t4_txd_async");
        chk(32'(count), 32'd0, "t4_count");
        chk(32'(busy), 32'd0, "t4_busy");
        chk(32'(overflow), 32'd0, "t4_overflow");
        chk(32'(full), 32'd0, "t4_full");
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 3 * F; k++) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        chk(32'(bad), 32'd0, "t4_quiet_after_release");

        // Write coinciding with the IDLE pop of a waiting byte.
        write_byte(8'h3C);
        write_byte(8'h96);
        expect_frame(8'h3C, 0, "t5a");
        chk(32'(count), 32'd1, "t5_count_wait");
        write_byte(8'hC5);
        chk(32'(count), 32'd1, "t5_count_pop_wr");
        expect_frame(8'h96, 0, "t5b");
        chk(32'(txd), 32'd1, "t5_gap_txd");
        tick();
        chk(32'(count), 32'd0, "t5_count_end");
        expect_frame(8'hC5, 0, "t5c");
        chk(32'(busy), 32'd0, "t5_busy_end");

        // 0x07 (odd weight) and 0x03 (even weight): parity slot when enabled.
        write_byte(8'h07);
        tick();
        expect_frame(8'h07, 0, "t6_07");
        chk(32'(busy), 32'd0, "t6_07_len");
        write_byte(8'h03);
        tick();
        expect_frame(8'h03, 0, "t6_03");
        chk(32'(busy), 32'd0, "t6_03_len");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
